reg_bcd_converter: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3, one bit per clock).

---
 rtl/reg_bcd_converter_pkg.sv | 18 +
 rtl/reg_bcd_converter_if.sv | 22 ++
 rtl/reg_bcd_converter_bcd_digit_adj.sv | 12 +
 rtl/reg_bcd_converter.sv | 110 +++++++++++
 tb/tb_reg_bcd_converter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_bcd_converter_pkg.sv
// Shared constants for the binary-to-BCD converter: default sizes,
// FSM state encoding and the counter-width helper.
package reg_bcd_converter_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned DIGITS_DEF = 10;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/reg_bcd_converter_if.sv
// Request/result bus between the CPU debug port and the BCD converter.
interface reg_bcd_converter_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
);
    logic [WIDTH-1:0]    i_data;
    logic                i_valid;
    logic                o_ready;
    logic [4*DIGITS-1:0] o_bcd;
    logic                o_valid;
    logic                o_busy;

    modport master (
        output i_data, i_valid,
        input  o_ready, o_bcd, o_valid, o_busy
    );

    modport slave (
        input  i_data, i_valid,
        output o_ready, o_bcd, o_valid, o_busy
    );
endinterface

// File: rtl/reg_bcd_converter_bcd_digit_adj.sv
// Add-3 correction for one BCD digit ahead of the shift; a 4-bit add,
// so digits 5..9 map to 8..12 without carry out.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_c_o
);

    always_comb begin
        digit_c_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
    end

endmodule

// File: rtl/reg_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock,
// with a double-buffered result so the display never sees a partial value.
module reg_bcd_converter
    import reg_bcd_converter_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter bit          AUTO   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_bcd_converter_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned BCD_W = 4 * DIGITS;

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] bin_q,   bin_d;
    logic [WIDTH-1:0] last_q,  last_d;
    logic [BCD_W-1:0] bcd_q,   bcd_d;
    logic [BCD_W-1:0] out_q,   out_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             busy_q;
    logic [BCD_W-1:0] bcd_adj_c;
    logic             start_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i   (bcd_q[4*g +: 4]),
            .digit_c_o (bcd_adj_c[4*g +: 4])
        );
    end

    // With AUTO, a changed input restarts the conversion without a request.
    always_comb begin
        start_c = bus.i_valid | (AUTO & (bus.i_data != last_q));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        last_d  = last_q;
        out_d   = out_q;
        valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    bin_d   = bus.i_data;
                    last_d  = bus.i_data;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj_c, bin_q} << 1;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_d   = bcd_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            last_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            last_q  <= last_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= ~ready_d;
        end
    end

    assign bus.o_bcd   = out_q;
    assign bus.o_valid = valid_q;
    assign bus.o_ready = ready_q;
    assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_reg_bcd_converter.sv
// Directed plus random checks of reg_bcd_converter against a decimal
// reference built from repeated division by ten.
module tb_reg_bcd_converter;

    logic clk;
    logic rst_n;

    reg_bcd_converter_if #(.WIDTH(32), .DIGITS(10)) b0 ();
    reg_bcd_converter_if #(.WIDTH(32), .DIGITS(10)) b1 ();

    reg_bcd_converter #(.WIDTH(32), .DIGITS(10), .AUTO(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    reg_bcd_converter #(.WIDTH(32), .DIGITS(10), .AUTO(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    logic [39:0] prev0;

    function automatic logic [39:0] ref_bcd(input longint unsigned v);
        logic [39:0]     r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a request on dut0 and wait for its result; leaves the bench in the
    // cycle where o_valid is high, so a following call starts back-to-back.
    task automatic run_conv0(input logic [31:0] v, input string tag);
        int lat;
        bit stable;
        bit rdy_ok;
        chk({tag, "_ready_at_req"}, 64'(b0.o_ready), 64'd1);
        b0.i_data  = v;
        b0.i_valid = 1'b1;
        tick();
        b0.i_valid = 1'b0;
        lat    = 0;
        stable = 1'b1;
        rdy_ok = 1'b1;
        while (b0.o_valid !== 1'b1 && lat <= 100) begin
            if (b0.o_bcd !== prev0) stable = 1'b0;
            if (b0.o_ready !== 1'b0 || b0.o_busy !== 1'b1) rdy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_bcd"}, 64'(b0.o_bcd), 64'(ref_bcd(64'(v))));
        chk({tag, "_stable"}, 64'(stable), 64'd1);
        chk({tag, "_busy_window"}, 64'(rdy_ok), 64'd1);
        prev0 = ref_bcd(64'(v));
    endtask

    task automatic wait_pulse1(output int n);
        n = 0;
        while (b1.o_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          pulses;
        int          n;
        logic [39:0] got;
        logic [31:0] v;

        vectors     = 0;
        miscompares = 0;
        prev0       = '0;
        rst_n       = 1'b0;
        b0.i_data   = '0;
        b0.i_valid  = 1'b0;
        b1.i_data   = '0;
        b1.i_valid  = 1'b0;
        repeat (2) tick();

        chk("reset_ready", 64'(b0.o_ready), 64'd1);
        chk("reset_busy",  64'(b0.o_busy),  64'd0);
        chk("reset_valid", 64'(b0.o_valid), 64'd0);
        chk("reset_bcd",   64'(b0.o_bcd),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Zero input: exact 33-cycle latency, result zero.
        run_conv0(32'd0, "zero");
        tick();
        chk("zero_pulse_width", 64'(b0.o_valid), 64'd0);

        // Known values, then all-ones issued back-to-back from the pulse cycle.
        run_conv0(32'd12345, "v12345");
        chk("v12345_const", 64'(b0.o_bcd), 64'h00_0001_2345);
        run_conv0(32'hFFFF_FFFF, "ones");
        chk("ones_const", 64'(b0.o_bcd), 64'h42_9496_7295);
        tick();

        // A second request mid-conversion is dropped.
        b0.i_data  = 32'd13579;
        b0.i_valid = 1'b1;
        tick();
        b0.i_valid = 1'b0;
        repeat (9) tick();
        b0.i_data  = 32'd24680;
        b0.i_valid = 1'b1;
        tick();
        b0.i_valid = 1'b0;
        pulses = 0;
        got    = '0;
        repeat (80) begin
            if (b0.o_valid === 1'b1) begin
                pulses++;
                got = b0.o_bcd;
            end
            tick();
        end
        chk("ignore_pulses", 64'(pulses), 64'd1);
        chk("ignore_bcd", 64'(got), 64'(ref_bcd(64'd13579)));

        // Reset mid-conversion clears the result and suppresses the pulse.
        b0.i_data  = 32'd777;
        b0.i_valid = 1'b1;
        tick();
        b0.i_valid = 1'b0;
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_bcd",   64'(b0.o_bcd),   64'd0);
        chk("abort_ready", 64'(b0.o_ready), 64'd1);
        chk("abort_valid", 64'(b0.o_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (60) begin
            tick();
            if (b0.o_valid === 1'b1) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        prev0 = '0;

        // AUTO instance: changed input self-starts, steady input does not.
        b1.i_data = 32'd7;
        wait_pulse1(n);
        chk("auto7_latency", 64'(n), 64'd34);
        chk("auto7_bcd", 64'(b1.o_bcd), 64'h7);
        b1.i_data = 32'd99;
        tick();
        chk("auto_pulse_width", 64'(b1.o_valid), 64'd0);
        wait_pulse1(n);
        chk("auto99_latency", 64'(n), 64'd33);
        chk("auto99_bcd", 64'(b1.o_bcd), 64'h99);
        pulses = 0;
        repeat (80) begin
            tick();
            if (b1.o_valid === 1'b1) pulses++;
        end
        chk("auto_steady_pulses", 64'(pulses), 64'd0);
        chk("auto_steady_ready", 64'(b1.o_ready), 64'd1);

        // Random values, including decade and width boundaries.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = (($urandom & 1) != 0) ? 32'd999_999_999 : 32'd1_000_000_000;
                default: v = $urandom;
            endcase
            run_conv0(v, "rand");
            if (($urandom & 3) == 0) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
